// File: rtl/lap_control_pkg.sv
// Shared types and constants for the stopwatch front-panel sequencer.
//   state_t     : sequencer states
//   time_rec_t  : one time value {tenths, seconds, minutes}, 16 bits
//   MAX_*       : largest displayable time, 9:59.9
package lap_control_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SPLIT,
    STOP,
    RECALL
  } state_t;

  typedef struct packed {
    logic [3:0] q0;
    logic [7:0] qs;
    logic [3:0] qm;
  } time_rec_t;

  localparam logic [3:0] MAX_Q0 = 4'd9;
  localparam logic [7:0] MAX_QS = 8'd59;
  localparam logic [3:0] MAX_QM = 4'd9;

endpackage

// File: rtl/lap_control_buffer.sv
// lap_buffer: LAPS-entry register file holding captured split times.
// Storage has no reset; entries are only meaningful below the lap count.
//   clk   : system clock
//   we    : write enable, writes wdata to mem[waddr] on the rising edge
//   waddr : write address
//   wdata : time record to store
//   raddr : asynchronous read address
//   rdata : mem[raddr]
module lap_buffer
  import lap_control_pkg::*;
#(
  parameter int unsigned LAPS  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  time_rec_t        wdata,
  input  logic [IDX_W-1:0] raddr,
  output time_rec_t        rdata
);

  time_rec_t mem [LAPS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lap_control.sv
// lap_control: two-button stopwatch sequencer. Drives the timing group's
// count enable and clear, captures splits into a lap buffer, recalls them
// after stopping, and muxes the time shown on the display.
// Optional build macro STOPWATCH_SATURATE_EN: stop at 9:59.9 instead of
// letting the timing group wrap.
//   clk, reset           : clock, asynchronous active-high reset
//   ss_pulse, lr_pulse   : start/stop and lap/reset one-cycle presses
//   live_q0/qs/qm        : live time from the timing group
//   count, clr           : timing enable, one-cycle synchronous clear
//   disp_q0/qs/qm, hold  : displayed time, high when showing a stored value
//   lap_cnt, lap_idx     : laps stored, lap currently recalled
//   lap_full             : lap buffer full
module lap_control
  import lap_control_pkg::*;
#(
  parameter int unsigned LAPS  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ss_pulse,
  input  logic             lr_pulse,
  input  logic [3:0]       live_q0,
  input  logic [7:0]       live_qs,
  input  logic [3:0]       live_qm,
  output logic             count,
  output logic             clr,
  output logic [3:0]       disp_q0,
  output logic [7:0]       disp_qs,
  output logic [3:0]       disp_qm,
  output logic             hold,
  output logic [IDX_W:0]   lap_cnt,
  output logic [IDX_W-1:0] lap_idx,
  output logic             lap_full
);

  state_t           state, state_n;
  logic [IDX_W:0]   cnt_n;
  logic [IDX_W-1:0] idx_n;
  time_rec_t        split, split_n;
  logic             clr_n;
  logic             we;
  logic             sat;
  time_rec_t        live, lap_rd, disp;
  logic [IDX_W:0]   idx_inc;

  assign live = '{q0: live_q0, qs: live_qs, qm: live_qm};

`ifdef STOPWATCH_SATURATE_EN
  assign sat = ((state == RUN) || (state == SPLIT)) &&
               (live_q0 == MAX_Q0) && (live_qs == MAX_QS) && (live_qm == MAX_QM);
`else
  assign sat = 1'b0;
`endif

  assign lap_full = (lap_cnt == (IDX_W+1)'(LAPS));
  assign idx_inc  = {1'b0, lap_idx} + (IDX_W+1)'(1);

  lap_buffer #(
    .LAPS  (LAPS),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (lap_cnt[IDX_W-1:0]),
    .wdata (live),
    .raddr (lap_idx),
    .rdata (lap_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lap_cnt <= '0;
      lap_idx <= '0;
      split   <= '0;
      clr     <= 1'b0;
    end else begin
      state   <= state_n;
      lap_cnt <= cnt_n;
      lap_idx <= idx_n;
      split   <= split_n;
      clr     <= clr_n;
    end
  end

  // Saturation outranks both buttons; ss outranks lr everywhere.
  always_comb begin
    state_n = state;
    cnt_n   = lap_cnt;
    idx_n   = lap_idx;
    split_n = split;
    clr_n   = 1'b0;
    we      = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_pulse) state_n = RUN;
      end
      RUN: begin
        if (sat || ss_pulse) begin
          state_n = STOP;
        end else if (lr_pulse) begin
          split_n = live;
          state_n = SPLIT;
          if (!lap_full) begin
            we    = 1'b1;
            cnt_n = lap_cnt + (IDX_W+1)'(1);
          end
        end
      end
      SPLIT: begin
        if (sat || ss_pulse) state_n = STOP;
        else if (lr_pulse)   state_n = RUN;
      end
      STOP: begin
        if (ss_pulse) begin
          state_n = RUN;
        end else if (lr_pulse) begin
          idx_n = '0;
          if (lap_cnt != '0) begin
            state_n = RECALL;
          end else begin
            state_n = IDLE;
            clr_n   = 1'b1;
          end
        end
      end
      RECALL: begin
        if (ss_pulse) begin
          state_n = STOP;
          idx_n   = '0;
        end else if (lr_pulse) begin
          if (idx_inc < lap_cnt) begin
            idx_n = lap_idx + IDX_W'(1);
          end else begin
            state_n = IDLE;
            clr_n   = 1'b1;
            cnt_n   = '0;
            idx_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    disp = live;
    if (state == SPLIT)  disp = split;
    if (state == RECALL) disp = lap_rd;
  end

  assign count   = ((state == RUN) || (state == SPLIT)) && !sat;
  assign hold    = (state == SPLIT) || (state == RECALL);
  assign disp_q0 = disp.q0;
  assign disp_qs = disp.qs;
  assign disp_qm = disp.qm;

endmodule

// File: tb/tb_lap_control.sv
module tb_lap_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ss_pulse = 1'b0, lr_pulse = 1'b0;
  logic [3:0] live_q0 = '0;
  logic [7:0] live_qs = '0;
  logic [3:0] live_qm = '0;
  logic       count, clr, hold, lap_full;
  logic [3:0] disp_q0, disp_qm;
  logic [7:0] disp_qs;
  logic [2:0] lap_cnt;
  logic [1:0] lap_idx;

  int checks = 0;
  int errors = 0;

  lap_control #(.LAPS(4), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .ss_pulse(ss_pulse), .lr_pulse(lr_pulse),
    .live_q0(live_q0), .live_qs(live_qs), .live_qm(live_qm),
    .count(count), .clr(clr), .disp_q0(disp_q0), .disp_qs(disp_qs),
    .disp_qm(disp_qm), .hold(hold), .lap_cnt(lap_cnt), .lap_idx(lap_idx),
    .lap_full(lap_full)
  );

  always #5 clk = ~clk;

  // time as {tenths, seconds, minutes}, matching the DUT record layout
  function automatic logic [15:0] tm(input int m, input int s, input int t);
    return {4'(t), 8'(s), 4'(m)};
  endfunction

  // {count, clr, hold, disp[15:0], lap_cnt[2:0], lap_idx[1:0], lap_full}
  function automatic logic [24:0] ex(input logic c, input logic cl, input logic h,
                                     input logic [15:0] d, input int n,
                                     input int i, input logic f);
    return {c, cl, h, d, 3'(n), 2'(i), f};
  endfunction

  function automatic logic [24:0] obs();
    return {count, clr, hold, disp_q0, disp_qs, disp_qm, lap_cnt, lap_idx, lap_full};
  endfunction

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step(input logic s, input logic l, input logic [15:0] lv);
    @(negedge clk);
    ss_pulse = s;
    lr_pulse = l;
    {live_q0, live_qs, live_qm} = lv;
    @(posedge clk);
    #1;
    ss_pulse = 1'b0;
    lr_pulse = 1'b0;
  endtask

  typedef struct {
    logic        ss;
    logic        lr;
    logic [15:0] live;
    logic [24:0] exp;
  } vec_t;

  vec_t v [21];
  logic sat_en;

  initial begin
`ifdef STOPWATCH_SATURATE_EN
    sat_en = 1'b1;
`else
    sat_en = 1'b0;
`endif
    // main table: starts in IDLE right after reset
    v[0]  = '{1'b0, 1'b1, tm(0,0,0),  ex(0,0,0, tm(0,0,0),  0,0,0)}; // lr ignored in IDLE
    v[1]  = '{1'b1, 1'b0, tm(0,0,0),  ex(1,0,0, tm(0,0,0),  0,0,0)}; // start
    v[2]  = '{1'b0, 1'b0, tm(0,12,3), ex(1,0,0, tm(0,12,3), 0,0,0)};
    v[3]  = '{1'b0, 1'b1, tm(0,12,3), ex(1,0,1, tm(0,12,3), 1,0,0)}; // split 1
    v[4]  = '{1'b0, 1'b0, tm(0,13,0), ex(1,0,1, tm(0,12,3), 1,0,0)}; // frozen
    v[5]  = '{1'b0, 1'b1, tm(0,14,1), ex(1,0,0, tm(0,14,1), 1,0,0)}; // release
    v[6]  = '{1'b0, 1'b1, tm(0,20,5), ex(1,0,1, tm(0,20,5), 2,0,0)};
    v[7]  = '{1'b0, 1'b1, tm(0,21,0), ex(1,0,0, tm(0,21,0), 2,0,0)};
    v[8]  = '{1'b0, 1'b1, tm(0,30,0), ex(1,0,1, tm(0,30,0), 3,0,0)};
    v[9]  = '{1'b0, 1'b1, tm(0,31,0), ex(1,0,0, tm(0,31,0), 3,0,0)};
    v[10] = '{1'b0, 1'b1, tm(0,40,0), ex(1,0,1, tm(0,40,0), 4,0,1)}; // full
    v[11] = '{1'b0, 1'b1, tm(0,41,0), ex(1,0,0, tm(0,41,0), 4,0,1)};
    v[12] = '{1'b0, 1'b1, tm(0,50,7), ex(1,0,1, tm(0,50,7), 4,0,1)}; // shown, not stored
    v[13] = '{1'b0, 1'b1, tm(0,51,0), ex(1,0,0, tm(0,51,0), 4,0,1)};
    v[14] = '{1'b1, 1'b1, tm(0,55,0), ex(0,0,0, tm(0,55,0), 4,0,1)}; // ss wins -> STOP
    v[15] = '{1'b0, 1'b1, tm(0,55,0), ex(0,0,1, tm(0,12,3), 4,0,1)}; // recall 0
    v[16] = '{1'b0, 1'b1, tm(0,55,0), ex(0,0,1, tm(0,20,5), 4,1,1)};
    v[17] = '{1'b0, 1'b1, tm(0,55,0), ex(0,0,1, tm(0,30,0), 4,2,1)};
    v[18] = '{1'b0, 1'b1, tm(0,55,0), ex(0,0,1, tm(0,40,0), 4,3,1)}; // fifth split absent
    v[19] = '{1'b0, 1'b1, tm(0,55,0), ex(0,1,0, tm(0,55,0), 0,0,0)}; // -> IDLE, clr
    v[20] = '{1'b0, 1'b0, tm(0,55,0), ex(0,0,0, tm(0,55,0), 0,0,0)}; // clr one cycle

    #1;
    chk("reset", obs(), ex(0,0,0, tm(0,0,0), 0,0,0));
    @(negedge clk);
    reset = 1'b0;

    for (int unsigned i = 0; i < 21; i++) begin
      step(v[i].ss, v[i].lr, v[i].live);
      chk($sformatf("vec%0d", i), obs(), v[i].exp);
    end

    // start latency: count low before the edge, high after
    @(negedge clk);
    ss_pulse = 1'b1;
    {live_q0, live_qs, live_qm} = tm(0,0,0);
    #1 chk("pre_start_count", 25'(count), 25'(0));
    @(posedge clk);
    #1 ss_pulse = 1'b0;
    chk("post_start", obs(), ex(1,0,0, tm(0,0,0), 0,0,0));
    step(1, 1, tm(0,2,0));
    chk("both_stop", obs(), ex(0,0,0, tm(0,2,0), 0,0,0));
    step(0, 1, tm(0,2,0));
    chk("stop_clear", obs(), ex(0,1,0, tm(0,2,0), 0,0,0));
    step(0, 0, tm(0,0,0));
    chk("clr_drop", obs(), ex(0,0,0, tm(0,0,0), 0,0,0));

    // two laps, split-to-stop, recall, leave and re-enter recall
    step(1, 0, tm(0,0,0));
    step(0, 1, tm(0,5,0));
    chk("lapA", obs(), ex(1,0,1, tm(0,5,0), 1,0,0));
    step(1, 0, tm(0,6,0));
    chk("split_stop", obs(), ex(0,0,0, tm(0,6,0), 1,0,0));
    step(1, 0, tm(0,6,0));
    step(0, 1, tm(0,9,2));
    step(0, 1, tm(0,10,0));
    step(1, 0, tm(0,11,0));
    step(0, 1, tm(0,11,0));
    chk("recA", obs(), ex(0,0,1, tm(0,5,0), 2,0,0));
    step(0, 1, tm(0,11,0));
    chk("recB", obs(), ex(0,0,1, tm(0,9,2), 2,1,0));
    step(1, 0, tm(0,11,0));
    chk("recall_exit", obs(), ex(0,0,0, tm(0,11,0), 2,0,0));
    step(0, 1, tm(0,11,0));
    chk("recA2", obs(), ex(0,0,1, tm(0,5,0), 2,0,0));
    step(0, 1, tm(0,11,0));
    step(0, 1, tm(0,11,0));
    chk("recall_clear", obs(), ex(0,1,0, tm(0,11,0), 0,0,0));
    step(0, 0, tm(0,11,0));
    chk("recall_clr_drop", obs(), ex(0,0,0, tm(0,11,0), 0,0,0));

    // asynchronous reset from SPLIT
    step(1, 0, tm(0,1,0));
    step(0, 1, tm(0,1,0));
    #2 reset = 1'b1;
    #1 chk("async_reset", obs(), ex(0,0,0, tm(0,1,0), 0,0,0));
    @(negedge clk);
    reset = 1'b0;

    // end-of-range behaviour
    step(1, 0, tm(0,0,0));
    @(negedge clk);
    {live_q0, live_qs, live_qm} = tm(9,59,9);
    #1 chk("max_count", 25'(count), sat_en ? 25'(0) : 25'(1));
    @(posedge clk);
    #1;
    if (sat_en) chk("max_edge", obs(), ex(0,0,0, tm(9,59,9), 0,0,0));
    else        chk("max_edge", obs(), ex(1,0,0, tm(9,59,9), 0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
